// File: rtl/mem_bus_responder.sv
// Line-oriented memory responder: 8-beat write bursts into a local store and
// 8-beat read bursts returned after a fixed latency, with tag echo.
module mem_bus_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam int OP_BIT = 12;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] LATENCY = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]               state_q;
  logic [AW-4:0]            line_q;
  logic [2:0]               beat_q;
  logic [LW-1:0]            lat_q;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic [AW-1:0]            word_addr;
  logic                     accept_hdr;
  logic                     accept_wr;

  logic [BUS_DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

  // Line base has bits [2:0] clear, so base+beat never carries into line bits.
  assign word_addr  = {line_q, beat_q};
  assign accept_hdr = !reset && (state_q == IDLE) && bus_reqcyc;
  assign accept_wr  = !reset && (state_q == WR_DATA) && bus_reqcyc;
  assign bus_reqack = accept_hdr || accept_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_reqcyc) begin
            line_q  <= bus_req[AW+2:6];
            tag_q   <= bus_reqtag;
            beat_q  <= '0;
            lat_q   <= LW'(READ_LATENCY - 1);
            state_q <= bus_reqtag[OP_BIT] ? LATENCY : WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus_reqcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) state_q <= IDLE;
          end
        end
        LATENCY: begin
          if (lat_q == '0) state_q <= RESP;
          else             lat_q   <= lat_q - 1'b1;
        end
        RESP: begin
          if (bus_respack) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store is deliberately left out of reset so aborted bursts keep written beats.
  always_ff @(posedge clk) begin
    if (accept_wr) mem[word_addr] <= bus_req;
  end

  assign bus_respcyc = !reset && (state_q == RESP);
  assign bus_resp    = bus_respcyc ? mem[word_addr] : '0;
  assign bus_resptag = bus_respcyc ? tag_q : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: a reference store predicts each
// read beat, a negedge monitor pops and compares, and drives respack stalls.
module tb_mem_bus_responder;

  logic        clk = 0;
  logic        reset = 1;
  logic        bus_reqcyc = 0;
  logic        bus_reqack;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_respcyc;
  logic        bus_respack = 1;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  mem_bus_responder dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mdl [0:4095];
  logic [76:0] sb [$];

  int ack_cnt = 0;
  int rise_cyc = 0;
  int last_pop_cyc = 0;
  int pop_cyc [8];
  int beat_idx = 0;
  int stall_beat = -1;
  int stall_left = 0;
  bit prev_stall = 0;
  bit prev_respcyc = 0;
  logic [63:0] prev_resp;
  logic [12:0] prev_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs 2ns after each negedge, after the driver has settled its inputs.
  always @(negedge clk) begin
    logic [76:0] e;
    #2;
    if (bus_reqack) ack_cnt++;
    if (bus_respcyc && !prev_respcyc) rise_cyc = cyc;
    if (bus_respcyc) begin
      if (prev_stall) begin
        check("stable_data", bus_resp, prev_resp);
        check("stable_tag", 64'(bus_resptag), 64'(prev_tag));
      end
      if (stall_left > 0 && beat_idx == stall_beat) begin
        bus_respack = 0;
        stall_left--;
        prev_stall = 1;
        prev_resp = bus_resp;
        prev_tag = bus_resptag;
      end else begin
        bus_respack = 1;
        prev_stall = 0;
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("data_b%0d", beat_idx), bus_resp, e[63:0]);
          check($sformatf("tag_b%0d", beat_idx), 64'(bus_resptag), 64'(e[76:64]));
        end
        pop_cyc[beat_idx] = cyc;
        last_pop_cyc = cyc;
        beat_idx = (beat_idx + 1) % 8;
      end
    end else begin
      bus_respack = 1;
      prev_stall = 0;
    end
    prev_respcyc = bus_respcyc;
  end

  // Called at a negedge; holds the beat until acked, returns at the next negedge.
  task automatic drive(input logic [63:0] d, input logic [12:0] t, input int maxw,
                       output int waited, output int acc_cyc);
    bus_reqcyc = 1;
    bus_req = d;
    bus_reqtag = t;
    #1;
    waited = 0;
    while (!bus_reqack && waited < maxw) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus_reqack) check("ack_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    bus_reqcyc = 0;
  endtask

  function automatic int widx(input logic [63:0] addr, input int i);
    return (int'((addr >> 3) & 64'hFFF) & ~7) + i & 4095;
  endfunction

  task automatic write_line(input logic [63:0] addr, input logic [11:0] id,
                            input logic [63:0] base, input bit stalls);
    int w, a;
    drive(addr, {1'b0, id}, 20, w, a);
    for (int i = 0; i < 8; i++) begin
      if (stalls && (i % 3 == 1)) @(negedge clk);
      drive(base + 64'(i), {1'b0, id}, 20, w, a);
      mdl[widx(addr, i)] = base + 64'(i);
    end
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag, input int maxw,
                           output int t_acc, output int waited);
    for (int i = 0; i < 8; i++) sb.push_back({tag, mdl[widx(addr, i)]});
    drive(addr, tag, maxw, waited, t_acc);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    #3;
    check("respcyc_drop", 64'(bus_respcyc), 64'd0);
  endtask

  initial begin
    int t_a, t_b, w, a0;
    logic [63:0] rnd;
    repeat (3) @(negedge clk);
    #3;
    bus_reqcyc = 1;
    #1;
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    bus_reqcyc = 0;
    @(negedge clk);
    reset = 0;

    // Basic write then read, latency and throughput.
    a0 = ack_cnt;
    write_line(64'h1000, 12'h005, 64'hA0, 1);
    #3;
    check("wr_ack_count", 64'(ack_cnt - a0), 64'd9);
    read_line(64'h1000, 13'h1005, 20, t_a, w);
    wait_done();
    check("rd_latency", 64'(rise_cyc - t_a), 64'd5);
    check("rd_b2b", 64'(pop_cyc[7] - rise_cyc), 64'd7);

    // Respack withheld for 3 cycles on beat 2.
    @(negedge clk);
    rnd = {$urandom, $urandom};
    write_line(64'h4040, 12'h0AB, rnd, 0);
    stall_beat = 2;
    stall_left = 3;
    read_line(64'h4040, 13'h10AB, 20, t_a, w);
    wait_done();
    check("stall_gap", 64'(pop_cyc[2] - pop_cyc[1]), 64'd4);
    check("after_stall", 64'(pop_cyc[3] - pop_cyc[2]), 64'd1);
    stall_beat = -1;

    // Second header arrives during LATENCY of the first read.
    @(negedge clk);
    write_line(64'h8000, 12'h033, 64'h5500, 0);
    read_line(64'h1000, 13'h1111, 20, t_a, w);
    read_line(64'h8000, 13'h1222, 60, t_b, w);
    check("hdr2_accept", 64'(t_b - last_pop_cyc), 64'd1);
    check("hdr2_waited", 64'(w > 5), 64'd1);
    wait_done();

    // Reset after 3 write beats of a line previously holding old data.
    @(negedge clk);
    write_line(64'h2000, 12'h044, 64'hB0, 0);
    drive(64'h2000, 13'h0044, 20, w, t_a);
    for (int i = 0; i < 3; i++) begin
      drive(64'hC0 + 64'(i), 13'h0044, 20, w, t_a);
      mdl[widx(64'h2000, i)] = 64'hC0 + 64'(i);
    end
    bus_reqcyc = 1;
    bus_req = 64'hC3;
    reset = 1;
    #3;
    check("mid_rst_reqack", 64'(bus_reqack), 64'd0);
    check("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
    @(negedge clk);
    #3;
    check("mid_rst_resp", bus_resp, 64'd0);
    check("mid_rst_resptag", 64'(bus_resptag), 64'd0);
    reset = 0;
    bus_reqcyc = 0;
    read_line(64'h2000, 13'h1044, 20, t_a, w);
    check("post_rst_first_acc", 64'(w), 64'd0);
    wait_done();

    // Address aliasing: 0x3FFC0 and 0x7FFFC0 both map to words 4088..4095.
    @(negedge clk);
    write_line(64'h3FFC0, 12'h077, 64'hD00, 0);
    check("wrap_index", 64'(widx(64'h7FFFC0, 0)), 64'd4088);
    read_line(64'h7FFFC0, 13'h1077, 20, t_a, w);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
